// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half adders; the serial adder's datapath cell.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (
    .a    (a),
    .b    (b),
    .sum  (s1),
    .cout (c1)
  );

  half_adder u_ha1 (
    .a    (s1),
    .b    (cin),
    .sum  (sum),
    .cout (c2)
  );

  // At most one of the two half-adder carries can be set, so OR is exact.
  assign cout = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts one operand pair, adds LSB first over WIDTH cycles,
// then holds sum/cout/ovf until the consumer takes them.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1. in_ready/out_valid depend only on state, never on in_valid/out_ready.

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             c;
  logic             cout_r;
  logic             ovf_r;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .a    (a_r[0]),
    .b    (b_r[0]),
    .cin  (c),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      c      <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            c     <= cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_r   <= a_r >> 1;
          b_r   <= b_r >> 1;
          sum_r <= {fa_sum, sum_r[WIDTH-1:1]};
          c     <= fa_cout;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            // c still holds the carry into the MSB cell on this edge.
            cout_r <= fa_cout;
            ovf_r  <= c ^ fa_cout;
            cnt    <= '0;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder (WIDTH=8): directed corner cases, backpressure, reset
// abort, throughput and randomized traffic against an arithmetic reference model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [1:0]   dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W+1:0] exp_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model: {ovf, cout, sum} ----------------
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c);
    int u;
    int s;
    logic [W-1:0] r;
    logic co;
    logic ov;
    u  = int'(x) + int'(y) + int'(c);
    r  = u[W-1:0];
    co = (u > 255);
    s  = int'($signed(x)) + int'($signed(y)) + int'(c);
    ov = (s > 127) || (s < -128);
    return {ov, co, r};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    a = ta;
    b = tb;
    cin = tc;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts rising edges until out_valid is seen at a falling edge; ends on a falling edge.
  task automatic wait_out(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    n_cmp++;
    if ({out_valid, sum, cout, ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b, want all 0",
               out_valid, sum, cout, ovf);
    end
    n_cmp++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[4] = '{8'h0F, 8'hFF, 8'h7F, 8'hFF};
    logic [W-1:0] tb[4] = '{8'h01, 8'h01, 8'h01, 8'h00};
    logic         tc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [W+1:0] te[4] = '{10'h010, 10'h100, 10'h280, 10'h100};
    int lat;
    for (int i = 0; i < 4; i++) begin
      accept(ta[i], tb[i], tc[i]);
      wait_out(lat);
      n_cmp++;
      if (lat !== W) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, W);
      end
      n_cmp++;
      if ({ovf, cout, sum} !== te[i]) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: got ovf=%b cout=%b sum=%h want %h",
                 i, ovf, cout, sum, te[i]);
      end
      release_out();
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_return_idle[%0d]: got in_ready=%b out_valid=%b", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    accept(8'h3C, 8'h5A, 1'b1);
    wait_out(lat);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = W'($urandom);
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {ovf, cout, sum} !== ref_model(8'h3C, 8'h5A, 1'b1))
        bad++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: %0d of 5 cycles not held (valid=%b sum=%h)", bad, out_valid, sum);
    end
    release_out();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_ignore_in_valid();
    int lat;
    int extra;
    accept(8'h01, 8'h02, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    a = 8'hAA;
    b = 8'h55;
    in_valid = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_in_ready: got %b want 0 during run", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(lat);
    n_cmp++;
    if (lat !== 5 || {ovf, cout, sum} !== 10'h003) begin
      n_fail++;
      $display("FAIL ignore_result: got lat=%0d ovf=%b cout=%b sum=%h want 5/0/0/03", lat, ovf, cout, sum);
    end
    release_out();
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL ignore_no_second: %0d cycles busy after single result, want 0", extra);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int stale;
    accept(8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, sum, cout, ovf} !== '0 || dbg_state !== 2'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_reset: got valid=%b sum=%h cout=%b ovf=%b state=%0d rdy=%b want zeros/idle",
               out_valid, sum, cout, ovf, dbg_state, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    n_cmp++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL midrun_no_result: out_valid seen %0d cycles after abort, want 0", stale);
    end
    accept(8'h10, 8'h20, 1'b0);
    wait_out(lat);
    n_cmp++;
    if (lat !== W || sum !== 8'h30 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_next: got lat=%0d sum=%h cout=%b want 8/30/0", lat, sum, cout);
    end
    release_out();
  endtask

  task automatic test_throughput();
    int cyc;
    int seen[$];
    a = 8'h21;
    b = 8'h43;
    cin = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cyc = 0;
    while (seen.size() < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (out_valid === 1'b1) seen.push_back(cyc);
    end
    in_valid = 1'b0;
    n_cmp++;
    if (seen.size() != 3) begin
      n_fail++;
      $display("FAIL throughput_count: got %0d results want 3", seen.size());
    end else if ((seen[1] - seen[0]) != W + 2 || (seen[2] - seen[1]) != W + 2) begin
      n_fail++;
      $display("FAIL throughput_gap: got %0d,%0d want %0d", seen[1] - seen[0], seen[2] - seen[1], W + 2);
    end
    repeat (12) @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int sent;
    int got;
    int cyc;
    logic [W+1:0] e;
    sent = 0;
    got = 0;
    cyc = 0;
    exp_q.delete();
    while (got < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 1) == 1);
      if (!in_valid || in_ready) begin
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom_range(0, 1));
      end
      in_valid = (sent < 1000);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(a, b, cin));
        sent++;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL random_dup: result %h with no outstanding transaction", {ovf, cout, sum});
        end else begin
          e = exp_q.pop_front();
          if ({ovf, cout, sum} !== e) begin
            n_fail++;
            $display("FAIL random_result[%0d]: got %h want %h", got, {ovf, cout, sum}, e);
          end
        end
        got++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (got != 1000 || sent != 1000 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_totals: got sent=%0d received=%0d pending=%0d want 1000/1000/0",
               sent, got, exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_ignore_in_valid();
    test_reset_mid_run();
    test_throughput();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
